// File: rtl/delay_unit_pkg.sv
// Shared types and default widths for the coarse delay stage.
package delay_unit_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned PW_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } coarse_state_t;

endpackage

// File: rtl/trigger_edge_detect.sv
// Rising-edge detector for the external trigger with a registered,
// one-cycle edge output. With COARSE_DELAY_TRIG_SYNC_EN defined the
// trigger first passes through a two-flop synchronizer (+2 cycles latency).
module trigger_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic edge_o
);

  logic trig_s;
  logic prev_q;
  logic edge_q;

`ifdef COARSE_DELAY_TRIG_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for the asynchronous external trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], trig_i};
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trig_i;
`endif

  // Edge fires in the cycle the sample is 1 and the previous sample was 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      prev_q <= trig_s;
      edge_q <= trig_s & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/coarse_delay.sv
// Coarse delay stage: one-shot, armed trigger delay in whole clk cycles
// followed by a pulse of programmable width. Optional trigger
// synchronizer selected by macro COARSE_DELAY_TRIG_SYNC_EN.
module coarse_delay
  import delay_unit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PW_W  = PW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_in,
  input  logic [CNT_W-1:0] coarse_delay_cycles,
  input  logic [PW_W-1:0]  pulse_width_cycles,
  input  logic             coarse_update,
  input  logic             arm,
  input  logic             abort,
  output logic             trigger_out,
  output logic             armed,
  output logic             busy,
  output logic [7:0]       missed_count
);

  coarse_state_t    state_q, state_d;
  logic [CNT_W-1:0] d_shadow_q;
  logic [PW_W-1:0]  w_shadow_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0]  w_act_q, w_act_d;
  logic [PW_W-1:0]  pcnt_q, pcnt_d;
  logic [7:0]       missed_q, missed_d;
  logic             edge_det;

  trigger_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trigger_in),
    .edge_o (edge_det)
  );

  // Shadow registers: only written by the update strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_shadow_q <= '0;
      w_shadow_q <= '0;
    end else if (coarse_update) begin
      d_shadow_q <= coarse_delay_cycles;
      w_shadow_q <= pulse_width_cycles;
    end
  end

  // State, counters and missed-edge counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_act_q  <= '0;
      pcnt_q   <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_act_q  <= w_act_d;
      pcnt_q   <= pcnt_d;
      missed_q <= missed_d;
    end
  end

  // Next-state logic; counters hold (value-1) so D = 2^CNT_W-1 never overflows
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_act_d  = w_act_q;
    pcnt_d   = pcnt_q;
    missed_d = missed_q;

    if (edge_det && (state_q == DELAY || state_q == PULSE) && missed_q != 8'hFF)
      missed_d = missed_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (edge_det) begin
          w_act_d = w_shadow_q;
          if (d_shadow_q == '0) begin
            state_d = PULSE;
            pcnt_d  = (w_shadow_q == '0) ? '0 : w_shadow_q - PW_W'(1);
          end else begin
            state_d = DELAY;
            cnt_d   = d_shadow_q - CNT_W'(1);
          end
        end
      end
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          pcnt_d  = (w_act_q == '0) ? '0 : w_act_q - PW_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (pcnt_q == '0) state_d = IDLE;
        else              pcnt_d  = pcnt_q - PW_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
  end

  assign trigger_out  = (state_q == PULSE);
  assign armed        = (state_q == ARMED);
  assign busy         = (state_q == DELAY) || (state_q == PULSE);
  assign missed_count = missed_q;

endmodule

// File: doc/coarse_delay.md
COARSE_DELAY -- requirements
Module: coarse_delay

Interface
REQ-001 Parameter CNT_W, default 32, sets the width of the delay counter and of coarse_delay_cycles.
REQ-002 Parameter PW_W, default 16, sets the width of the pulse-width counter and of pulse_width_cycles.
REQ-003 clk  input  1  system clock, 100 MHz, the same clock that drives the fine delay stage; the block has one clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 trigger_in  input  1  external trigger; its rising edge starts a delay.
REQ-006 coarse_delay_cycles  input  CNT_W  delay D, in clk cycles.
REQ-007 pulse_width_cycles  input  PW_W  output pulse width W, in clk cycles.
REQ-008 coarse_update  input  1  one-cycle strobe that latches D and W into the shadow registers.
REQ-009 arm  input  1  one-cycle strobe that arms the block for one trigger.
REQ-010 abort  input  1  one-cycle strobe that cancels any activity and returns the block to IDLE.
REQ-011 trigger_out  output  1  delayed pulse; drives the trigger_in input of the fine delay stage.
REQ-012 armed  output  1  high while the state is ARMED.
REQ-013 busy  output  1  high while the state is DELAY or PULSE.
REQ-014 missed_count  output  8  count of ignored trigger edges; saturates at 255.

Function
REQ-015 FSM states SHALL be IDLE, ARMED, DELAY and PULSE.
REQ-016 IDLE -> ARMED on arm; an edge that arrives in the same cycle as arm is not captured.
REQ-017 ARMED -> DELAY on a detected rising edge; the active D and W are copied from the shadow registers at this point.
REQ-018 Edge detection: an edge is detected in a cycle where the sampled trigger is 1 and the previous sample was 0; a trigger already high when arm is asserted produces no edge.
REQ-019 Timing: with the edge sampled on clk edge N, trigger_out is high for cycles N+D+1 through N+D+W inclusive (registered output).
REQ-020 D=0: the block goes from ARMED directly to PULSE, and trigger_out rises at N+1.
REQ-021 W=0 SHALL be treated as W=1.
REQ-022 PULSE -> IDLE after W cycles (one-shot operation); the next trigger requires a new arm.
REQ-023 An edge detected in DELAY or PULSE is ignored and increments missed_count; the count saturates at 255 and does not wrap.
REQ-024 arm in DELAY or PULSE is ignored; arm in ARMED has no effect.
REQ-025 abort in any state goes to IDLE, and trigger_out is low on the next cycle.
REQ-026 abort together with arm: abort wins and the state is IDLE.
REQ-027 coarse_update in any state updates only the shadow registers; a delay already running keeps its captured D and W.
REQ-028 Counters SHALL be unsigned; D = 2^CNT_W-1 SHALL work without overflow.

Reset
REQ-029 On rst: state IDLE; trigger_out, armed, busy and missed_count all 0; shadow and active D and W are 0; edge history is 0.
REQ-030 rst asserted during DELAY or PULSE drops trigger_out asynchronously; after rst is released the block requires a new arm.

Configuration
REQ-031 Macro COARSE_DELAY_TRIG_SYNC_EN compiled in: trigger_in passes through a two-flop synchronizer before edge detection, and all latencies in REQ-019 and REQ-020 grow by 2 cycles.
REQ-032 Macro COARSE_DELAY_TRIG_SYNC_EN compiled out: trigger_in is sampled directly, and timing is exactly as in REQ-019.

Structure
REQ-033 Package delay_unit_pkg SHALL hold the coarse_state_t enum and the default constants CNT_W_DEF and PW_W_DEF.
REQ-034 Sub-module trigger_edge_detect SHALL contain the optional synchronizer and the rising-edge detector, with a one-cycle edge output.

Verification
REQ-035 With D=5, W=3: update, arm, then an edge sampled at cycle 10 -> trigger_out is high in cycles 16-18; armed and busy fall as specified.
REQ-036 With D=0, W=0: arm, then an edge at cycle 4 -> trigger_out is high only in cycle 5.
REQ-037 With D=100: after arming, three further edges during DELAY -> missed_count=3 and the output timing is unchanged; 300 such edges -> missed_count=255.
REQ-038 With D=50: abort at 20 cycles into DELAY -> no pulse and state IDLE; arm together with abort -> armed stays 0.
REQ-039 coarse_update to D=2 while running with D=40 -> the current pulse fires at D=40 and the next armed trigger fires at D=2.
REQ-040 rst asserted asynchronously during PULSE -> trigger_out is 0 immediately; with COARSE_DELAY_TRIG_SYNC_EN defined, the REQ-035 pulse appears in cycles 18-20.
